// File: rtl/uart_cmd_decoder.sv
// UART receiver that decodes header-tagged command bytes into a first-word
// fall-through command FIFO, flagging framing, parity and header errors.
module uart_cmd_decoder #(
  parameter int unsigned       CLKS_PER_BIT = 434,
  parameter int unsigned       CMD_W        = 3,
  parameter logic [7-CMD_W:0]  HEADER       = 5'b10100,
  parameter int unsigned       PARITY       = 0,
  parameter int unsigned       FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          iData,
  output logic [CMD_W-1:0]              oCmd,
  output logic                          oCmd_valid,
  input  logic                          iCmd_ready,
  output logic                          oFrame_err,
  output logic                          oParity_err,
  output logic                          oHdr_err,
  output logic                          oOverflow,
  output logic [$clog2(FIFO_DEPTH):0]   oCount
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned NW = AW + 1;
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t           state;
  logic [1:0]       sync;
  logic             rx;
  logic             rx_d;
  logic [CW-1:0]    cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             par_bit;
  logic             par_x_c;
  logic             par_bad_c;
  logic             push_v;
  logic [CMD_W-1:0] push_cmd;

  assign rx = sync[1];

  // Line synchronizer plus one-cycle delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
      rx_d <= 1'b1;
    end else begin
      sync <= {sync[0], iData};
      rx_d <= rx;
    end
  end

  always_comb begin
    par_x_c   = ^{shreg, par_bit};
    par_bad_c = ((PARITY == 1) && par_x_c) || ((PARITY == 2) && !par_x_c);
  end

  // Receiver FSM: error pulses and push request are single-cycle by default
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      oFrame_err  <= 1'b0;
      oParity_err <= 1'b0;
      oHdr_err    <= 1'b0;
      push_v      <= 1'b0;
      push_cmd    <= '0;
    end else begin
      oFrame_err  <= 1'b0;
      oParity_err <= 1'b0;
      oHdr_err    <= 1'b0;
      push_v      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_d && !rx) begin
            state   <= S_START;
            cnt     <= '0;
            bit_idx <= '0;
          end
        end
        S_START: begin
          if (cnt == HALF_END) begin
            cnt   <= '0;
            state <= rx ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt == BIT_END) begin
            cnt     <= '0;
            shreg   <= {rx, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_PARITY: begin
          if (cnt == BIT_END) begin
            cnt     <= '0;
            par_bit <= rx;
            state   <= S_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt == BIT_END) begin
            cnt <= '0;
            if (!rx) begin
              oFrame_err <= 1'b1;
              state      <= S_WAIT_HIGH;
            end else begin
              state <= S_IDLE;
              if (par_bad_c) begin
                oParity_err <= 1'b1;
              end else if (shreg[7:CMD_W] != HEADER) begin
                oHdr_err <= 1'b1;
              end else begin
                push_v   <= 1'b1;
                push_cmd <= shreg[CMD_W-1:0];
              end
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WAIT_HIGH: begin
          // A held break must not look like a fresh start bit
          if (rx) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [CMD_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_c;
  logic             full_c;
  logic             wr_c;
  logic             ovf_c;
  logic [AW-1:0]    rd_next_c;
  logic [NW-1:0]    count_next_c;
  logic [NW-1:0]    remain_c;
  logic [CMD_W-1:0] head_next_c;

  // Next head is computed ahead so oCmd can be a registered output
  always_comb begin
    pop_c        = oCmd_valid && iCmd_ready;
    full_c       = (oCount == NW'(FIFO_DEPTH));
    wr_c         = push_v && (!full_c || pop_c);
    ovf_c        = push_v && full_c && !pop_c;
    rd_next_c    = rd_ptr + AW'(pop_c);
    count_next_c = oCount + NW'(wr_c) - NW'(pop_c);
    remain_c     = oCount - NW'(pop_c);
    head_next_c  = oCmd;
    if (remain_c != '0) head_next_c = mem[rd_next_c];
    else if (wr_c)      head_next_c = push_cmd;
  end

  always_ff @(posedge clk) begin
    if (wr_c) mem[wr_ptr] <= push_cmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      oCount     <= '0;
      oCmd       <= '0;
      oCmd_valid <= 1'b0;
      oOverflow  <= 1'b0;
    end else begin
      if (wr_c) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= rd_next_c;
      oCount     <= count_next_c;
      oCmd_valid <= (count_next_c != '0);
      oCmd       <= head_next_c;
      oOverflow  <= ovf_c;
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed vector table, corner
// sequences and a randomized run against a queue-based command model.
module tb_uart_cmd_decoder;

  localparam int CPB = 16;
  localparam logic [4:0] HDR = 5'b10100;

  logic clk = 1'b0;
  logic rst_n;
  logic rx0, rx1, rdy0, rdy1;
  logic [2:0] cmd0, cmd1, cnt0, cnt1;
  logic valid0, valid1, fe0, pe0, he0, ov0, fe1, pe1, he1, ov1;

  always #5 clk = ~clk;

  uart_cmd_decoder #(.CLKS_PER_BIT(CPB), .CMD_W(3), .HEADER(HDR), .PARITY(0), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .iData(rx0), .oCmd(cmd0), .oCmd_valid(valid0),
    .iCmd_ready(rdy0), .oFrame_err(fe0), .oParity_err(pe0), .oHdr_err(he0),
    .oOverflow(ov0), .oCount(cnt0));

  uart_cmd_decoder #(.CLKS_PER_BIT(CPB), .CMD_W(3), .HEADER(HDR), .PARITY(1), .FIFO_DEPTH(4)) dutp (
    .clk(clk), .rst_n(rst_n), .iData(rx1), .oCmd(cmd1), .oCmd_valid(valid1),
    .iCmd_ready(rdy1), .oFrame_err(fe1), .oParity_err(pe1), .oHdr_err(he1),
    .oOverflow(ov1), .oCount(cnt1));

  int n_chk = 0;
  int n_fail = 0;
  int n_fe[2], n_pe[2], n_he[2], n_ov[2];
  int s_fe[2], s_pe[2], s_he[2], s_ov[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      n_fe[i] = 0; n_pe[i] = 0; n_he[i] = 0; n_ov[i] = 0;
    end
  end

  always @(negedge clk) begin
    n_fe[0] += int'(fe0); n_pe[0] += int'(pe0); n_he[0] += int'(he0); n_ov[0] += int'(ov0);
    n_fe[1] += int'(fe1); n_pe[1] += int'(pe1); n_he[1] += int'(he1); n_ov[1] += int'(ov1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic snap(input int sel);
    s_fe[sel] = n_fe[sel]; s_pe[sel] = n_pe[sel];
    s_he[sel] = n_he[sel]; s_ov[sel] = n_ov[sel];
  endtask

  task automatic chk_pulses(input int sel, input string name,
                            input int fe, input int pe, input int he, input int ov);
    chk({name, " frame_err"}, n_fe[sel] - s_fe[sel], fe);
    chk({name, " parity_err"}, n_pe[sel] - s_pe[sel], pe);
    chk({name, " hdr_err"}, n_he[sel] - s_he[sel], he);
    chk({name, " overflow"}, n_ov[sel] - s_ov[sel], ov);
  endtask

  task automatic send_bit(input int sel, input logic b);
    @(negedge clk);
    if (sel == 0) rx0 = b; else rx1 = b;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input logic stop,
                            input bit with_par, input logic pbit);
    send_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
    if (with_par) send_bit(sel, pbit);
    send_bit(sel, stop);
  endtask

  task automatic idle(input int sel, input int n);
    @(negedge clk);
    if (sel == 0) rx0 = 1'b1; else rx1 = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_expect(input string name, input int exp);
    @(negedge clk);
    chk({name, " valid"}, int'(valid0), 1);
    chk({name, " cmd"}, int'(cmd0), exp);
    rdy0 = 1'b1;
    @(negedge clk);
    rdy0 = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         fe;
    int         he;
    int         count;
    int         head;
  } vec_t;

  vec_t tbl[6];
  int   q[$];
  logic [7:0] d;
  logic stop_ok;
  int   efe, ehe, eov, k;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'hA7, 1'b1, 0, 0, 1, 7};
    tbl[1] = '{8'h37, 1'b1, 0, 1, 1, 7};
    tbl[2] = '{8'hA1, 1'b0, 1, 0, 1, 7};
    tbl[3] = '{8'hB5, 1'b1, 0, 1, 1, 7};
    tbl[4] = '{8'hA2, 1'b1, 0, 0, 2, 7};
    tbl[5] = '{8'h05, 1'b0, 1, 0, 2, 7};

    rx0 = 1'b1; rx1 = 1'b1; rdy0 = 1'b0; rdy1 = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset cmd", int'(cmd0), 0);
    chk("reset valid", int'(valid0), 0);
    chk("reset count", int'(cnt0), 0);
    chk("reset pulses", int'({fe0, pe0, he0, ov0, fe1, pe1, he1, ov1}), 0);
    chk("reset count p", int'(cnt1), 0);
    rst_n = 1'b1;
    idle(0, 4);

    // Directed vector table, consumer stalled
    for (int i = 0; i < 6; i++) begin
      snap(0);
      send_frame(0, tbl[i].data, tbl[i].stop, 1'b0, 1'b0);
      idle(0, 4);
      chk_pulses(0, $sformatf("vec%0d", i), tbl[i].fe, 0, tbl[i].he, 0);
      chk($sformatf("vec%0d count", i), int'(cnt0), tbl[i].count);
      chk($sformatf("vec%0d valid", i), int'(valid0), 1);
      chk($sformatf("vec%0d head", i), int'(cmd0), tbl[i].head);
    end
    pop_expect("drain0", 7);
    pop_expect("drain1", 2);
    @(negedge clk);
    chk("drain empty count", int'(cnt0), 0);
    chk("drain empty valid", int'(valid0), 0);

    // Ready while empty is ignored
    rdy0 = 1'b1;
    repeat (3) @(negedge clk);
    rdy0 = 1'b0;
    chk("empty ready count", int'(cnt0), 0);

    // Back-to-back frames into a stalled FIFO
    snap(0);
    for (int i = 0; i < 5; i++) send_frame(0, 8'hA0 + 8'(i), 1'b1, 1'b0, 1'b0);
    idle(0, 4);
    chk_pulses(0, "overflow seq", 0, 0, 0, 1);
    chk("overflow count", int'(cnt0), 4);
    for (int i = 0; i < 4; i++) pop_expect($sformatf("ovf pop%0d", i), i);
    @(negedge clk);
    chk("overflow drained", int'(cnt0), 0);

    // Stop bit held low for three bit times
    snap(0);
    send_bit(0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(0, tbl[0].data[i]);
    repeat (3) send_bit(0, 1'b0);
    idle(0, 4);
    chk_pulses(0, "break", 1, 0, 0, 0);
    chk("break count", int'(cnt0), 0);
    snap(0);
    send_frame(0, 8'hA2, 1'b1, 1'b0, 1'b0);
    idle(0, 4);
    chk_pulses(0, "after break", 0, 0, 0, 0);
    chk("after break count", int'(cnt0), 1);
    pop_expect("after break", 2);

    // Even parity on the second instance
    snap(1);
    send_frame(1, 8'hA5, 1'b1, 1'b1, 1'b1);
    idle(1, 4);
    chk_pulses(1, "bad parity", 0, 1, 0, 0);
    chk("bad parity valid", int'(valid1), 0);
    snap(1);
    send_frame(1, 8'hA5, 1'b1, 1'b1, 1'b0);
    idle(1, 4);
    chk_pulses(1, "good parity", 0, 0, 0, 0);
    chk("good parity valid", int'(valid1), 1);
    chk("good parity cmd", int'(cmd1), 5);

    // Short low glitch must not start a frame
    snap(0);
    @(negedge clk); rx0 = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx0 = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk_pulses(0, "glitch", 0, 0, 0, 0);
    chk("glitch count", int'(cnt0), 0);
    send_frame(0, 8'hA3, 1'b1, 1'b0, 1'b0);
    idle(0, 4);
    chk("post glitch cmd", int'(cmd0), 3);

    // Reset in the middle of the data bits
    send_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(0, 1'b1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("midreset count", int'(cnt0), 0);
    chk("midreset valid", int'(valid0), 0);
    chk("midreset cmd", int'(cmd0), 0);
    chk("midreset count p", int'(cnt1), 0);
    rx0 = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(0, 4);
    snap(0);
    send_frame(0, 8'hA6, 1'b1, 1'b0, 1'b0);
    idle(0, 4);
    chk_pulses(0, "post reset", 0, 0, 0, 0);
    chk("post reset count", int'(cnt0), 1);
    pop_expect("post reset", 6);

    // Randomized frames against a queue model
    for (int it = 0; it < 30; it++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) d[7:3] = HDR;
      stop_ok = ($urandom_range(0, 6) != 0);
      efe = stop_ok ? 0 : 1;
      ehe = (stop_ok && d[7:3] != HDR) ? 1 : 0;
      eov = 0;
      if (stop_ok && ehe == 0) begin
        if (q.size() == 4) eov = 1;
        else q.push_back(int'(d[2:0]));
      end
      snap(0);
      send_frame(0, d, stop_ok, 1'b0, 1'b0);
      idle(0, 4);
      chk_pulses(0, $sformatf("rand%0d", it), efe, 0, ehe, eov);
      chk($sformatf("rand%0d count", it), int'(cnt0), q.size());
      chk($sformatf("rand%0d valid", it), int'(valid0), (q.size() != 0) ? 1 : 0);
      if (q.size() != 0) chk($sformatf("rand%0d head", it), int'(cmd0), q[0]);
      k = $urandom_range(0, q.size());
      repeat (k) pop_expect($sformatf("rand%0d pop", it), q.pop_front());
    end
    while (q.size() != 0) pop_expect("rand drain", q.pop_front());
    @(negedge clk);
    chk("final count", int'(cnt0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (>=4).
REQ-002 Parameter CMD_W, default 3, command field width (1..7).
REQ-003 Parameter HEADER, default 5'b10100, width 8-CMD_W; required value of byte[7:CMD_W].
REQ-004 Parameter PARITY, default 0, mode: 0 none, 1 even, 2 odd.
REQ-005 Parameter FIFO_DEPTH, default 4, command FIFO entries (power of 2, >=2).
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 iData  input  1  asynchronous UART serial line, idle high.
REQ-009 oCmd  output  CMD_W  command at FIFO head.
REQ-010 oCmd_valid  output  1  FIFO non-empty; oCmd is valid.
REQ-011 iCmd_ready  input  1  consumer accepts oCmd when high with oCmd_valid.
REQ-012 oFrame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-013 oParity_err  output  1  one-cycle pulse: parity mismatch.
REQ-014 oHdr_err  output  1  one-cycle pulse: byte header != HEADER.
REQ-015 oOverflow  output  1  one-cycle pulse: valid command dropped, FIFO full.
REQ-016 oCount  output  clog2(FIFO_DEPTH)+1  FIFO occupancy.

Function
REQ-017 iData shall pass through a 2-flop synchronizer before any use.
REQ-018 Receiver FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-019 IDLE -> START on synchronized high-to-low transition; bit counter cleared.
REQ-020 START samples line after CLKS_PER_BIT/2 cycles; low -> DATA, high -> IDLE (glitch, no error).
REQ-021 DATA samples 8 bits, LSB first, each CLKS_PER_BIT cycles after previous sample.
REQ-022 After bit 7: PARITY if PARITY!=0, else STOP; PARITY state samples one bit CLKS_PER_BIT later.
REQ-023 STOP samples CLKS_PER_BIT after last sample; high -> IDLE, low -> oFrame_err pulse, WAIT_HIGH.
REQ-024 WAIT_HIGH returns to IDLE only when synchronized line is high (break does not retrigger).
REQ-025 Error priority per byte: frame > parity > header; exactly one error pulse per bad byte; bad bytes never enter FIFO.
REQ-026 Even parity: XOR of 8 data bits and parity bit = 0; odd: = 1.
REQ-027 Good byte with byte[7:CMD_W]==HEADER pushes byte[CMD_W-1:0] into FIFO on cycle after stop sample.
REQ-028 FIFO first-word fall-through: oCmd_valid high and oCmd valid the cycle after push into empty FIFO.
REQ-029 Pop occurs on clk edge where oCmd_valid && iCmd_ready; iCmd_ready while empty ignored.
REQ-030 Push and pop same cycle: both performed, oCount unchanged, including when full.
REQ-031 Push when full without pop: command dropped, oOverflow pulses, FIFO contents unchanged.
REQ-032 Read/write pointers wrap modulo FIFO_DEPTH; oCount = writes - reads, 0..FIFO_DEPTH.
REQ-033 Receiver operation is independent of FIFO state; back-to-back frames accepted with no idle gap.

Reset
REQ-034 rst_n low asynchronously forces FSM IDLE, counters 0, synchronizer flops 1, FIFO empty.
REQ-035 Reset values: oCmd 0, oCmd_valid 0, oCount 0, all error/overflow pulses 0.
REQ-036 Reset mid-frame discards partial byte; after release, next falling edge starts a new frame.

Verification
REQ-037 Defaults, frame 0xA7 -> oCmd=3'b111, oCmd_valid=1, oCount=1, no error pulses.
REQ-038 Defaults, frame 0x37 -> oHdr_err one pulse, oCmd_valid stays 0.
REQ-039 PARITY=1, 0xA5 with parity bit 1 -> oParity_err pulse, no push; parity bit 0 -> oCmd=3'b101.
REQ-040 iCmd_ready=0, five frames 0xA0..0xA4 -> oCount=4, oOverflow once on fifth; pops yield 0,1,2,3.
REQ-041 Stop bit held low 3 bit-times then high, then 0xA2 -> one oFrame_err, then oCmd=3'b010.
REQ-042 Low glitch of CLKS_PER_BIT/4 cycles -> FSM back to IDLE, no pulses; rst_n low mid-DATA -> outputs reset, next 0xA6 -> oCmd=3'b110.
